// File: rtl/pixel_diffuser_pkg.sv
// pixel_diffuser_pkg
//   Shared definitions for the pixel diffuser: FSM state type, the
//   encrypt/decrypt mode encodings and the keystream byte width.
package pixel_diffuser_pkg;

  localparam int KEY_W = 8;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Only the low byte of the mixed chaotic keystream word is consumed.
  function automatic logic [KEY_W-1:0] key_byte(input logic [22:0] word);
    return word[KEY_W-1:0];
  endfunction

endpackage

// File: rtl/key_fifo.sv
// key_fifo
//   Small synchronous FIFO buffering keystream bytes.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     flush_i         synchronous flush (empties the FIFO, wins over push/pop)
//     push_i, din_i   write request and byte (ignored when full)
//     pop_i           read request (ignored when empty)
//     dout_o          head-of-queue byte (valid when not empty)
//     full_o, empty_o occupancy flags
module key_fifo
  import pixel_diffuser_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [KEY_W-1:0] din_i,
  input  logic             pop_i,
  output logic [KEY_W-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [KEY_W-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers alone
  // define which entries are meaningful, and an unreset array maps to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/pixel_diffuser.sv
// pixel_diffuser
//   Chained XOR diffusion of a pixel stream with a chaotic keystream.
//   Encrypt: C[i] = P[i] ^ K[i] ^ C[i-1]; decrypt: P[i] = C[i] ^ K[i] ^ C[i-1],
//   with C[-1] = iv. One key byte is consumed per pixel.
//   Ports:
//     clk, rst                      clock, asynchronous active-high reset
//     start, mode, iv               frame request, 0=enc/1=dec, chaining seed
//     key_in/key_valid/key_ready    keystream input (low byte used)
//     pix_in/pix_valid/pix_ready    pixel input stream
//     dat_out/dat_valid/dat_ready   result stream (1-cycle latency)
//     busy, done                    high in RUN, one-cycle frame-complete pulse
module pixel_diffuser
  import pixel_diffuser_pkg::*;
#(
  parameter int NPIX   = 65536,
  parameter int KDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [7:0]  iv,
  input  logic [22:0] key_in,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [7:0]  dat_out,
  output logic        dat_valid,
  input  logic        dat_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] LAST_IDX = 16'(NPIX - 1);

  state_t      state_q, state_d;
  logic        mode_q, mode_d;
  logic [7:0]  cprev_q, cprev_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  dat_out_q, dat_out_d;
  logic        dat_valid_q, dat_valid_d;

  logic             start_acc, pix_fire, last_pix;
  logic             fifo_full, fifo_empty;
  logic [KEY_W-1:0] key_head;
  logic [7:0]       result;
  logic             key_hi_unused;

  assign key_hi_unused = ^key_in[22:KEY_W];

  // Accepting start also flushes the FIFO, so keys offered in that cycle are refused.
  assign start_acc = (state_q == ST_IDLE) && start;
  assign key_ready = !rst && !fifo_full && !start_acc;
  assign pix_ready = (state_q == ST_RUN) && !fifo_empty && (!dat_valid_q || dat_ready);
  assign pix_fire  = pix_valid && pix_ready;
  assign last_pix  = (cnt_q == LAST_IDX);
  assign result    = pix_in ^ key_head ^ cprev_q;
  assign dat_out   = dat_out_q;
  assign dat_valid = dat_valid_q;

  key_fifo #(.DEPTH(KDEPTH)) u_key_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (start_acc),
    .push_i  (key_valid && key_ready),
    .din_i   (key_byte(key_in)),
    .pop_i   (pix_fire),
    .dout_o  (key_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (pix_fire && last_pix) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mode_d      = mode_q;
    cprev_d     = cprev_q;
    cnt_d       = cnt_q;
    dat_out_d   = dat_out_q;
    dat_valid_d = dat_valid_q;
    if (start_acc) begin
      mode_d  = mode;
      cprev_d = iv;
      cnt_d   = '0;
    end else if (pix_fire) begin
      // The chain always follows the ciphertext: our output when encrypting,
      // the incoming pixel when decrypting.
      cprev_d = (mode_q == MODE_DEC) ? pix_in : result;
      if (!last_pix) cnt_d = cnt_q + 16'd1;
    end
    if (pix_fire) begin
      dat_out_d   = result;
      dat_valid_d = 1'b1;
    end else if (dat_ready) begin
      dat_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_ENC;
      cprev_q     <= '0;
      cnt_q       <= '0;
      dat_out_q   <= '0;
      dat_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cprev_q     <= cprev_d;
      cnt_q       <= cnt_d;
      dat_out_q   <= dat_out_d;
      dat_valid_q <= dat_valid_d;
    end
  end

endmodule

// File: tb/tb_pixel_diffuser.sv
module tb_pixel_diffuser;

  localparam int NPIX   = 4;
  localparam int KDEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, mode;
  logic [7:0]  iv;
  logic [22:0] key_in;
  logic        key_valid, key_ready;
  logic [7:0]  pix_in;
  logic        pix_valid, pix_ready;
  logic [7:0]  dat_out;
  logic        dat_valid, dat_ready;
  logic        busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pixel_diffuser #(.NPIX(NPIX), .KDEPTH(KDEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .iv        (iv),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .dat_out   (dat_out),
    .dat_valid (dat_valid),
    .dat_ready (dat_ready),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic            mode;
    logic [7:0]      iv;
    logic [3:0][22:0] key;
    logic [3:0][7:0]  pix;
    logic [3:0][7:0]  exp;
    int              bp;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Reference: chained XOR straight from the cipher definition.
  function automatic logic [3:0][7:0] model(input logic m, input logic [7:0] v,
                                            input logic [3:0][22:0] k,
                                            input logic [3:0][7:0] p);
    logic [3:0][7:0] o;
    logic [7:0] chain;
    chain = v;
    for (int i = 0; i < 4; i++) begin
      o[i]  = p[i] ^ k[i][7:0] ^ chain;
      chain = m ? p[i] : o[i];
    end
    return o;
  endfunction

  task automatic run_frame(input logic m, input logic [7:0] v,
                           input logic [3:0][22:0] k, input logic [3:0][7:0] p,
                           input logic [3:0][7:0] e, input int bp, input string tag);
    int k_i, p_i, o_i, cyc, last_fire, done_cnt;
    k_i = 0; p_i = 0; o_i = 0; cyc = 0; last_fire = -100; done_cnt = 0;
    mode = m; iv = v; start = 1'b1;
    next();
    start = 1'b0;
    while (cyc < 300 && !(o_i == 4 && done_cnt >= 1 && cyc > last_fire + 3)) begin
      key_valid = (k_i < 4) && ($urandom_range(99) >= bp);
      key_in    = (k_i < 4) ? k[k_i] : 23'h0;
      pix_valid = (p_i < 4) && ($urandom_range(99) >= bp);
      pix_in    = (p_i < 4) ? p[p_i] : 8'h00;
      dat_ready = ($urandom_range(99) >= bp);
      @(negedge clk);
      if (done) begin
        done_cnt++;
        check({tag, "_done_timing"}, cyc, last_fire + 1);
      end
      if (key_valid && key_ready) k_i++;
      if (pix_valid && pix_ready) begin
        p_i++;
        if (p_i == 4) last_fire = cyc;
      end
      if (dat_valid && dat_ready) begin
        if (o_i < 4) check({tag, "_dat_out"}, dat_out, e[o_i]);
        else check({tag, "_extra_output"}, 1, 0);
        o_i++;
      end
      next();
      cyc++;
    end
    key_valid = 1'b0; pix_valid = 1'b0; dat_ready = 1'b0;
    check({tag, "_outputs_seen"}, o_i, 4);
    check({tag, "_done_count"}, done_cnt, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0][22:0] ks;
    logic [3:0][7:0]  rp;
    int done_cnt;

    // Hand-computed vectors: enc, dec, enc with junk upper key bits, enc under back-pressure.
    vecs[0] = '{mode: 1'b0, iv: 8'h5A, key: {23'h000033, 23'h000000, 23'h0000FF, 23'h000011},
                pix: {8'h40, 8'h30, 8'h20, 8'h10}, exp: {8'hC7, 8'hB4, 8'h84, 8'h5B}, bp: 0};
    vecs[1] = '{mode: 1'b1, iv: 8'h5A, key: {23'h000033, 23'h000000, 23'h0000FF, 23'h000011},
                pix: {8'hC7, 8'hB4, 8'h84, 8'h5B}, exp: {8'h40, 8'h30, 8'h20, 8'h10}, bp: 0};
    vecs[2] = '{mode: 1'b0, iv: 8'h5A, key: {23'h2AAA33, 23'h7FFF00, 23'h1234FF, 23'h7FFF11},
                pix: {8'h40, 8'h30, 8'h20, 8'h10}, exp: {8'hC7, 8'hB4, 8'h84, 8'h5B}, bp: 0};
    vecs[3] = '{mode: 1'b1, iv: 8'h5A, key: {23'h000033, 23'h000000, 23'h0000FF, 23'h000011},
                pix: {8'hC7, 8'hB4, 8'h84, 8'h5B}, exp: {8'h40, 8'h30, 8'h20, 8'h10}, bp: 40};

    rst = 1'b1; start = 1'b0; mode = 1'b0; iv = '0; key_in = '0; key_valid = 1'b0;
    pix_in = '0; pix_valid = 1'b0; dat_ready = 1'b0;
    #3;
    check("rst_dat_out",   dat_out,   8'h00);
    check("rst_dat_valid", dat_valid, 0);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_key_ready", key_ready, 0);
    check("rst_busy",      busy,      0);
    check("rst_done",      done,      0);
    #20 rst = 1'b0;
    next();
    check("idle_key_ready", key_ready, 1);

    for (int i = 0; i < 4; i++)
      run_frame(vecs[i].mode, vecs[i].iv, vecs[i].key, vecs[i].pix, vecs[i].exp, vecs[i].bp,
                $sformatf("vec%0d", i));

    // Starvation, full FIFO, output stall and drain after the frame ends.
    ks = {23'h000033, 23'h000000, 23'h0000FF, 23'h000011};
    mode = 1'b0; iv = 8'h5A; start = 1'b1;
    next();
    start = 1'b0; pix_valid = 1'b1; pix_in = 8'h10; dat_ready = 1'b0;
    @(negedge clk);
    check("starve_pix_ready", pix_ready, 0);
    check("starve_busy", busy, 1);
    next();
    pix_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'b1; key_in = ks[i];
      @(negedge clk);
      check("fill_key_ready", key_ready, 1);
      next();
    end
    key_in = 23'h000055;
    @(negedge clk);
    check("full_key_ready", key_ready, 0);
    next();
    key_valid = 1'b0; pix_valid = 1'b1; pix_in = 8'h10;
    @(negedge clk);
    check("first_pix_ready", pix_ready, 1);
    next();
    pix_in = 8'h20;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("stall_dat_valid", dat_valid, 1);
      check("stall_dat_out",   dat_out,   8'h5B);
      check("stall_pix_ready", pix_ready, 0);
      next();
    end
    dat_ready = 1'b1;
    @(negedge clk);
    check("release_pix_ready", pix_ready, 1);
    next();
    pix_in = 8'h30;
    @(negedge clk);
    check("stall_out1", dat_out, 8'h84);
    next();
    pix_in = 8'h40;
    @(negedge clk);
    check("stall_out2", dat_out, 8'hB4);
    next();
    pix_valid = 1'b0; dat_ready = 1'b0;
    @(negedge clk);
    check("stall_out3", dat_out, 8'hC7);
    check("stall_done", done, 1);
    next();
    @(negedge clk);
    check("drain_busy",      busy,      0);
    check("drain_done",      done,      0);
    check("drain_dat_valid", dat_valid, 1);
    check("drain_dat_out",   dat_out,   8'hC7);
    dat_ready = 1'b1;
    next();
    @(negedge clk);
    check("drained_dat_valid", dat_valid, 0);
    next();
    dat_ready = 1'b0;

    // Reset in the middle of a frame.
    mode = 1'b0; iv = 8'h5A; start = 1'b1;
    next();
    start = 1'b0; key_valid = 1'b1; key_in = 23'h11;
    next();
    key_in = 23'hFF;
    next();
    key_valid = 1'b0; pix_valid = 1'b1; pix_in = 8'h10;
    next();
    pix_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_dat_valid", dat_valid, 1);
    check("pre_rst_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_dat_out",   dat_out,   8'h00);
    check("mid_rst_dat_valid", dat_valid, 0);
    check("mid_rst_pix_ready", pix_ready, 0);
    check("mid_rst_key_ready", key_ready, 0);
    check("mid_rst_busy",      busy,      0);
    done_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    #2 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("mid_rst_no_done", done_cnt, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_key_ready", key_ready, 1);
    next();
    run_frame(vecs[0].mode, vecs[0].iv, vecs[0].key, vecs[0].pix, vecs[0].exp, 0, "recover");

    // Random frames against the reference model.
    for (int f = 0; f < 10; f++) begin
      logic m;
      logic [7:0] v;
      m = 1'($urandom_range(1));
      v = 8'($urandom);
      for (int i = 0; i < 4; i++) begin
        ks[i] = 23'($urandom);
        rp[i] = 8'($urandom);
      end
      run_frame(m, v, ks, rp, model(m, v, ks, rp), 30, $sformatf("rand%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_diffuser.md
PIXEL_DIFFUSER -- requirements
Module: pixel_diffuser

Interface
REQ-001 Parameter NPIX, default 65536, SHALL set the number of pixels per frame (256x256 image).
REQ-002 Parameter KDEPTH, default 4, SHALL set the keystream FIFO depth (power of two, >=2).
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 Port start  input  1  SHALL request a new frame; sampled only in IDLE.
REQ-006 Port mode  input  1  SHALL select the operation (0 = encrypt, 1 = decrypt); latched on accepted start.
REQ-007 Port iv  input  8  SHALL be the chaining seed; latched on accepted start.
REQ-008 Port key_in  input  23  SHALL carry the mixed chaotic keystream word; only bits [7:0] are used.
REQ-009 Port key_valid  input  1  SHALL qualify key_in.
REQ-010 Port key_ready  output  1  SHALL be high when the key FIFO can accept a word.
REQ-011 Port pix_in  input  8  SHALL carry the plaintext pixel (encrypt) or ciphertext pixel (decrypt).
REQ-012 Port pix_valid / pix_ready  input / output  1 each  SHALL form the pixel input handshake.
REQ-013 Port dat_out  output  8  SHALL carry the result pixel.
REQ-014 Port dat_valid / dat_ready  output / input  1 each  SHALL form the result handshake.
REQ-015 Port busy  output  1  SHALL be high in RUN.
REQ-016 Port done  output  1  SHALL pulse high for one cycle when a frame completes.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DONE.
REQ-018 IDLE->RUN SHALL occur on start=1; mode and iv are latched, the pixel counter is cleared and the key FIFO is flushed in the same cycle.
REQ-019 RUN->DONE SHALL occur on the transfer of pixel NPIX-1; DONE->IDLE SHALL follow unconditionally after one cycle, with done=1 during DONE.
REQ-020 start SHALL be ignored in RUN and DONE.
REQ-021 A key transfer SHALL occur when key_valid and key_ready are both high; key_ready = FIFO not full, in any state except the flush cycle.
REQ-022 pix_ready SHALL equal (state==RUN) AND FIFO not empty AND (dat_valid==0 OR dat_ready==1).
REQ-023 A pixel transfer SHALL pop exactly one key byte K.
REQ-024 In encrypt mode, dat_out SHALL equal P ^ K ^ Cprev, where Cprev is the previous dat_out (iv for pixel 0).
REQ-025 In decrypt mode, dat_out SHALL equal C ^ K ^ Cprev, where Cprev is the previous pix_in (iv for pixel 0).
REQ-026 Result latency SHALL be 1 cycle: dat_valid rises on the edge after the pixel transfer.
REQ-027 dat_valid and dat_out SHALL hold while dat_ready is low; dat_valid SHALL clear when dat_ready is high and no new transfer occurs.
REQ-028 A simultaneous key push and pop SHALL be allowed when the FIFO is neither full nor empty; when full, key_ready SHALL be low regardless of a pop.
REQ-029 The pixel counter SHALL be 16 bits wide and SHALL NOT wrap within a frame; the last pixel is detected at count NPIX-1.
REQ-030 The final result SHALL still drain through dat_valid/dat_ready after the FSM has returned to IDLE.

Reset
REQ-031 Reset SHALL force IDLE, FIFO empty, counter 0, Cprev 0, dat_out 0x00, dat_valid 0, pix_ready 0, key_ready 0, busy 0, done 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no done pulse; the partially processed frame is discarded.

Structure
REQ-033 A shared package SHALL hold the FSM state typedef, the MODE_ENC/MODE_DEC constants and the key-byte width (8).
REQ-034 The key buffer SHALL be a sub-module key_fifo (parameter DEPTH, width 8, synchronous flush input, full/empty outputs).

Verification
REQ-035 Encrypt, iv=0x5A, keys 0x000011 then 0x0000FF, pixels 0x10 then 0x20 -> dat_out 0x5B then 0x84.
REQ-036 Decrypt, same iv and keys, pixels 0x5B then 0x84 -> dat_out 0x10 then 0x20.
REQ-037 Key 0x7FFF11 in place of 0x000011 in REQ-035 -> identical outputs (upper bits ignored).
REQ-038 Hold dat_ready=0 for 5 cycles mid-frame -> dat_out stable, pix_ready=0, no key popped, no data lost.
REQ-039 Starve keys (FIFO empty) -> pix_ready=0; push KDEPTH keys with no pixels -> key_ready=0.
REQ-040 NPIX=4 frame -> done pulses exactly once, one cycle after the 4th transfer; assert rst mid-frame -> all outputs return to reset values and done stays 0.
